vx_sched_csr_src: RTL and testbench

VX_SCHED_CSR_SRC -- requirements
Module: VX_sched_csr_src

---
 rtl/vx_gpu_pkg.sv | 17 +
 rtl/vx_sched_csr_if.sv | 27 ++
 rtl/vx_popcount.sv | 17 +
 rtl/vx_sched_csr_src.sv | 88 ++++++++
 tb/tb_vx_sched_csr_src.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vx_gpu_pkg.sv
// Shared GPU constants for the scheduler CSR source.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

package vx_gpu_pkg;

  localparam int PERF_CTR_BITS = 44;

  function automatic int wid_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_sched_csr_if.sv
// Scheduler state exported to the CSR unit.
interface vx_sched_csr_if #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int CTR_BITS    = 44
);

  logic [CTR_BITS-1:0]  cycles;
  logic [CTR_BITS-1:0]  instret;
  logic [NUM_WARPS-1:0] active_warps;
  logic [NUM_WARPS-1:0][NUM_THREADS-1:0] thread_masks;

  modport master (
    output cycles,
    output instret,
    output active_warps,
    output thread_masks
  );

  modport slave (
    input cycles,
    input instret,
    input active_warps,
    input thread_masks
  );

endinterface

// File: rtl/vx_popcount.sv
// Combinational population count.
module vx_popcount #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] in_i,
  output logic [W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + W'(in_i[i]);
    end
  end

endmodule

// File: rtl/vx_sched_csr_src.sv
// Cycle/instret counters and warp activity state
// exported to the CSR unit.
module vx_sched_csr_src
  import vx_gpu_pkg::*;
#(
  parameter int NUM_WARPS    = `NUM_WARPS,
  parameter int NUM_THREADS  = `NUM_THREADS,
  parameter int COMMIT_WIDTH = 4,
  parameter int CTR_BITS     = PERF_CTR_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COMMIT_WIDTH-1:0]       commit_valid,
  input  logic                          wspawn_valid,
  input  logic [NUM_WARPS-1:0]          wspawn_mask,
  input  logic                          tmc_valid,
  input  logic [wid_bits(NUM_WARPS)-1:0] tmc_wid,
  input  logic [NUM_THREADS-1:0]        tmc_mask,
  output logic                          busy,
  vx_sched_csr_if.master                csr_if
);

  localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);
  localparam logic [NUM_THREADS-1:0] LANE0 = NUM_THREADS'(1);

  typedef logic [NUM_WARPS-1:0][NUM_THREADS-1:0] masks_t;

  logic [CTR_BITS-1:0]  cycles_q, cycles_d;
  logic [CTR_BITS-1:0]  instret_q, instret_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_WARPS-1:0] active_q, active_d;
  masks_t               masks_q, masks_d;
  logic                 tmc_hit;

  vx_popcount #(
    .N (COMMIT_WIDTH),
    .W (CNT_W)
  ) u_popcount (
    .in_i  (commit_valid),
    .cnt_o (cnt_d)
  );

  assign cycles_d  = cycles_q + CTR_BITS'(1);
  assign instret_d = instret_q + CTR_BITS'(cnt_q);
  assign tmc_hit   = (32'(tmc_wid) < 32'(NUM_WARPS));

  // TMC is applied after spawn so it wins on a shared warp.
  always_comb begin
    active_d = active_q;
    masks_d  = masks_q;
    if (wspawn_valid) begin
      for (int w = 1; w < NUM_WARPS; w++) begin
        if (wspawn_mask[w]) begin
          active_d[w] = 1'b1;
          masks_d[w]  = LANE0;
        end
      end
    end
    if (tmc_valid && tmc_hit) begin
      active_d[tmc_wid] = |tmc_mask;
      masks_d[tmc_wid]  = tmc_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycles_q   <= '0;
      instret_q  <= '0;
      cnt_q      <= '0;
      active_q   <= NUM_WARPS'(1);
      masks_q    <= '0;
      masks_q[0] <= LANE0;
    end else begin
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      masks_q   <= masks_d;
    end
  end

  assign busy                = |active_q;
  assign csr_if.cycles       = cycles_q;
  assign csr_if.instret      = instret_q;
  assign csr_if.active_warps = active_q;
  assign csr_if.thread_masks = masks_q;

endmodule

// File: tb/tb_vx_sched_csr_src.sv
// Randomised bench for vx_sched_csr_src with a cycle
// model plus fixed directed scenarios.
module tb_vx_sched_csr_src;

  localparam int NW = 4;
  localparam int NT = 4;
  localparam int CWD = 4;
  localparam int CB = 8;
  localparam int MOD = 1 << CB;

  logic          clk;
  logic          reset;
  logic [CWD-1:0] commit_valid;
  logic          wspawn_valid;
  logic [NW-1:0] wspawn_mask;
  logic          tmc_valid;
  logic [1:0]    tmc_wid;
  logic [NT-1:0] tmc_mask;
  logic          busy;

  vx_sched_csr_if #(
    .NUM_WARPS   (NW),
    .NUM_THREADS (NT),
    .CTR_BITS    (CB)
  ) csr_if ();

  vx_sched_csr_src #(
    .NUM_WARPS    (NW),
    .NUM_THREADS  (NT),
    .COMMIT_WIDTH (CWD),
    .CTR_BITS     (CB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (commit_valid),
    .wspawn_valid (wspawn_valid),
    .wspawn_mask  (wspawn_mask),
    .tmc_valid    (tmc_valid),
    .tmc_wid      (tmc_wid),
    .tmc_mask     (tmc_mask),
    .busy         (busy),
    .csr_if       (csr_if)
  );

  int nvec = 0;
  int nbad = 0;

  int cyc_m = 0;
  int ins_m = 0;
  int pend_m = 0;
  int act_m[NW];
  int msk_m[NW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int act_word();
    int v = 0;
    for (int w = 0; w < NW; w++) v += act_m[w] << w;
    return v;
  endfunction

  // Reference model: advance on each rising edge, compare 1ns later.
  always @(posedge clk) begin
    if (!reset) begin
      cyc_m = 0;
      ins_m = 0;
      pend_m = 0;
      for (int w = 0; w < NW; w++) begin
        act_m[w] = (w == 0) ? 1 : 0;
        msk_m[w] = (w == 0) ? 1 : 0;
      end
    end else begin
      cyc_m = (cyc_m + 1) % MOD;
      ins_m = (ins_m + pend_m) % MOD;
      pend_m = $countones(commit_valid);
      for (int w = 1; w < NW; w++) begin
        if (wspawn_valid && wspawn_mask[w]) begin
          act_m[w] = 1;
          msk_m[w] = 1;
        end
      end
      if (tmc_valid) begin
        msk_m[tmc_wid] = int'(tmc_mask);
        act_m[tmc_wid] = (tmc_mask != 0) ? 1 : 0;
      end
    end
    #1;
    chk("cycles", int'(csr_if.cycles), cyc_m);
    chk("instret", int'(csr_if.instret), ins_m);
    chk("active", int'(csr_if.active_warps), act_word());
    chk("busy", int'(busy), (act_word() != 0) ? 1 : 0);
    for (int w = 0; w < NW; w++)
      chk("tmask", int'(csr_if.thread_masks[w]), msk_m[w]);
  end

  task automatic idle();
    commit_valid = '0;
    wspawn_valid = 1'b0;
    wspawn_mask  = '0;
    tmc_valid    = 1'b0;
    tmc_wid      = '0;
    tmc_mask     = '0;
  endtask

  task automatic tmc(input int wid, input int m);
    tmc_valid = 1'b1;
    tmc_wid   = 2'(wid);
    tmc_mask  = NT'(m);
    @(negedge clk);
    idle();
  endtask

  task automatic commits(input int pat, input int n);
    commit_valid = CWD'(pat);
    repeat (n) @(negedge clk);
    commit_valid = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("lit_cycles10", int'(csr_if.cycles), 10);
    chk("lit_instret0", int'(csr_if.instret), 0);
    chk("lit_active1", int'(csr_if.active_warps), 1);
    chk("lit_mask0", int'(csr_if.thread_masks[0]), 1);
    chk("lit_busy1", int'(busy), 1);

    commits(4'b1011, 1);
    chk("lit_lat_hold", int'(csr_if.instret), 0);
    @(negedge clk);
    chk("lit_instret3", int'(csr_if.instret), 3);
    commits(4'b1111, 5);
    @(negedge clk);
    chk("lit_instret23", int'(csr_if.instret), 23);

    wspawn_valid = 1'b1;
    wspawn_mask  = 4'hF;
    @(negedge clk);
    idle();
    chk("lit_spawn_act", int'(csr_if.active_warps), 15);
    chk("lit_spawn_m1", int'(csr_if.thread_masks[1]), 1);
    chk("lit_spawn_m3", int'(csr_if.thread_masks[3]), 1);
    chk("lit_spawn_m0", int'(csr_if.thread_masks[0]), 1);

    tmc(1, 0);
    tmc(2, 0);
    tmc(3, 0);
    chk("lit_kill_act", int'(csr_if.active_warps), 1);
    wspawn_valid = 1'b1;
    wspawn_mask  = 4'h6;
    tmc(2, 0);
    chk("lit_prio_act", int'(csr_if.active_warps), 3);
    chk("lit_prio_m2", int'(csr_if.thread_masks[2]), 0);

    tmc(1, 0);
    tmc(0, 0);
    chk("lit_idle_act", int'(csr_if.active_warps), 0);
    chk("lit_idle_busy", int'(busy), 0);
    tmc(0, 5);
    chk("lit_w0_mask", int'(csr_if.thread_masks[0]), 5);

    commits(4'b1111, 57);
    commits(4'b0111, 1);
    repeat (2) @(negedge clk);
    chk("lit_pre_wrap", int'(csr_if.instret), 254);
    commits(4'b0111, 1);
    repeat (2) @(negedge clk);
    chk("lit_wrap1", int'(csr_if.instret), 1);

    commits(4'b1111, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("lit_rst_inflight", int'(csr_if.instret), 0);
    chk("lit_rst_act", int'(csr_if.active_warps), 1);

    for (int i = 0; i < 1500; i++) begin
      commit_valid = CWD'($urandom);
      wspawn_valid = ($urandom_range(0, 3) == 0);
      wspawn_mask  = NW'($urandom);
      tmc_valid    = ($urandom_range(0, 2) == 0);
      tmc_wid      = 2'($urandom);
      tmc_mask     = ($urandom_range(0, 3) == 0) ? '0 : NT'($urandom);
      reset        = ($urandom_range(0, 63) != 0);
      @(negedge clk);
    end
    idle();
    reset = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
